// File: rtl/rob_ctrl.sv
// -----------------------------------------------------------------------------
// rob_ctrl -- reorder-buffer control.
//
// Accepts up to four decoded instruction slots per cycle and stores them in
// program order in a circular buffer of DEPTH entries. Two writeback ports mark
// entries complete. Up to four completed entries per cycle retire in order.
// Retirement stops after the first mispredicted branch or jr. That entry still
// retires, and a one-cycle flush carrying its recovery PC is raised.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   inst_val_in[3:0]         per-slot valid, slot0 oldest
//   rcvr_pc_in[63:0]         16-bit recovery PC per slot
//   str_en_in, spec_brch_in, brch_pred_res_in, no_exe_in, jr_in [3:0]
//                            per-slot ROB fields
//   brch_mode_in[7:0]        2-bit predictor mode per slot
//   stall_out                ROB cannot accept this cycle
//   alloc_idx_out            entry index given to the oldest valid slot
//   cmpl{0,1}_val/_idx/_taken  writeback ports (port 0 has priority)
//   ret_val_out, ret_str_en_out, ret_brch_mode_out, ret_brch_taken_out
//                            registered retire bundle, slot0 oldest
//   flush_out, flush_pc_out  registered one-cycle flush and recovery PC
// -----------------------------------------------------------------------------
module rob_ctrl #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       inst_val_in,
  input  logic [63:0]      rcvr_pc_in,
  input  logic [3:0]       str_en_in,
  input  logic [3:0]       spec_brch_in,
  input  logic [7:0]       brch_mode_in,
  input  logic [3:0]       brch_pred_res_in,
  input  logic [3:0]       no_exe_in,
  input  logic [3:0]       jr_in,
  output logic             stall_out,
  output logic [PTR_W-1:0] alloc_idx_out,
  input  logic             cmpl0_val,
  input  logic             cmpl1_val,
  input  logic [PTR_W-1:0] cmpl0_idx,
  input  logic [PTR_W-1:0] cmpl1_idx,
  input  logic             cmpl0_taken,
  input  logic             cmpl1_taken,
  output logic [3:0]       ret_val_out,
  output logic [3:0]       ret_str_en_out,
  output logic [7:0]       ret_brch_mode_out,
  output logic [3:0]       ret_brch_taken_out,
  output logic             flush_out,
  output logic [15:0]      flush_pc_out
);

  // Pointer and occupancy state
  logic [PTR_W-1:0] head_q, tail_q;
  logic [PTR_W:0]   count_q;

  // Per-entry status and stored fields
  logic [DEPTH-1:0] valid_q, done_q, mispred_q, taken_q;
  logic [DEPTH-1:0] str_q, brch_q, pred_q, jr_q;
  logic [15:0]      pc_q   [DEPTH];
  logic [1:0]       mode_q [DEPTH];

  // Registered outputs
  logic [3:0]  ret_val_q, ret_str_q, ret_taken_q;
  logic [7:0]  ret_mode_q;
  logic        flush_q;
  logic [15:0] flush_pc_q;

  // ---------------------------------------------------------------------------
  // Allocation: valid slots are compacted, so each slot's entry is tail plus
  // the number of valid slots older than it.
  // ---------------------------------------------------------------------------
  logic [2:0]       alloc_off [4];
  logic [2:0]       alloc_cnt;
  logic [PTR_W-1:0] slot_idx  [4];
  logic             alloc_en;

  always_comb begin
    alloc_cnt = 3'd0;
    for (int s = 0; s < 4; s++) begin
      alloc_off[s] = alloc_cnt;
      alloc_cnt    = alloc_cnt + {2'b00, inst_val_in[s]};
    end
  end

  // Free space is judged on the registered count only; entries retiring this
  // cycle are not credited.
  assign stall_out     = ((PTR_W+1)'(DEPTH) - count_q) < (PTR_W+1)'(4);
  assign alloc_en      = !stall_out && !flush_q && (|inst_val_in);
  assign alloc_idx_out = tail_q;

  // ---------------------------------------------------------------------------
  // Retire window: head..head+3, limited to the number of occupied entries.
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0] win_idx  [4];
  logic [3:0]       win_ok, win_stop;
  logic [3:0]       ret_vec;
  logic [2:0]       ret_cnt;
  logic             ret_go;
  logic             flush_d;
  logic [15:0]      flush_pc_d;
  logic [3:0]       ret_str_d, ret_taken_d;
  logic [7:0]       ret_mode_d;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slot
      assign slot_idx[gi] = tail_q + PTR_W'(alloc_off[gi]);
      assign win_idx[gi]  = head_q + PTR_W'(gi);
      assign win_ok[gi]   = (count_q > (PTR_W+1)'(gi)) &&
                            valid_q[win_idx[gi]] && done_q[win_idx[gi]];
      // An entry that redirects the front end ends the retire group.
      assign win_stop[gi] = (brch_q[win_idx[gi]] && mispred_q[win_idx[gi]]) ||
                            jr_q[win_idx[gi]];
      assign ret_str_d[gi]   = ret_vec[gi] && str_q[win_idx[gi]];
      assign ret_taken_d[gi] = ret_vec[gi] && brch_q[win_idx[gi]] && taken_q[win_idx[gi]];
      assign ret_mode_d[2*gi +: 2] = (ret_vec[gi] && brch_q[win_idx[gi]]) ?
                                     mode_q[win_idx[gi]] : 2'b00;
    end
  endgenerate

  always_comb begin
    ret_vec    = 4'b0000;
    ret_cnt    = 3'd0;
    ret_go     = 1'b1;
    flush_d    = 1'b0;
    flush_pc_d = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      if (ret_go && win_ok[k]) begin
        ret_vec[k] = 1'b1;
        ret_cnt    = ret_cnt + 3'd1;
        if (win_stop[k]) begin
          flush_d    = 1'b1;
          flush_pc_d = pc_q[win_idx[k]];
          ret_go     = 1'b0;
        end
      end else begin
        ret_go = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Completion: ignored for invalid or already-done entries. When both ports
  // name the same entry, port 1 is dropped.
  // ---------------------------------------------------------------------------
  logic c0_hit, c1_hit;

  assign c0_hit = cmpl0_val && valid_q[cmpl0_idx] && !done_q[cmpl0_idx];
  assign c1_hit = cmpl1_val && !(cmpl0_val && (cmpl0_idx == cmpl1_idx)) &&
                  valid_q[cmpl1_idx] && !done_q[cmpl1_idx];

  // ---------------------------------------------------------------------------
  // State update
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      valid_q     <= '0;
      done_q      <= '0;
      mispred_q   <= '0;
      taken_q     <= '0;
      ret_val_q   <= '0;
      ret_str_q   <= '0;
      ret_taken_q <= '0;
      ret_mode_q  <= '0;
      flush_q     <= 1'b0;
      flush_pc_q  <= '0;
    end else begin
      ret_val_q   <= ret_vec;
      ret_str_q   <= ret_str_d;
      ret_taken_q <= ret_taken_d;
      ret_mode_q  <= ret_mode_d;
      flush_q     <= flush_d;
      flush_pc_q  <= flush_pc_d;

      if (flush_d) begin
        // Recovery empties the buffer; this cycle's allocation is dropped.
        valid_q <= '0;
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (ret_vec[k]) valid_q[win_idx[k]] <= 1'b0;
        end

        if (c1_hit) begin
          done_q[cmpl1_idx]    <= 1'b1;
          taken_q[cmpl1_idx]   <= cmpl1_taken;
          mispred_q[cmpl1_idx] <= brch_q[cmpl1_idx] && (cmpl1_taken != pred_q[cmpl1_idx]);
        end
        if (c0_hit) begin
          done_q[cmpl0_idx]    <= 1'b1;
          taken_q[cmpl0_idx]   <= cmpl0_taken;
          mispred_q[cmpl0_idx] <= brch_q[cmpl0_idx] && (cmpl0_taken != pred_q[cmpl0_idx]);
        end

        // Allocated entries are always free, so they never overlap with
        // retiring or completing entries.
        if (alloc_en) begin
          for (int s = 0; s < 4; s++) begin
            if (inst_val_in[s]) begin
              valid_q[slot_idx[s]]   <= 1'b1;
              done_q[slot_idx[s]]    <= no_exe_in[s];
              mispred_q[slot_idx[s]] <= 1'b0;
              taken_q[slot_idx[s]]   <= 1'b0;
              str_q[slot_idx[s]]     <= str_en_in[s];
              brch_q[slot_idx[s]]    <= spec_brch_in[s];
              pred_q[slot_idx[s]]    <= brch_pred_res_in[s];
              jr_q[slot_idx[s]]      <= jr_in[s];
              pc_q[slot_idx[s]]      <= rcvr_pc_in[16*s +: 16];
              mode_q[slot_idx[s]]    <= brch_mode_in[2*s +: 2];
            end
          end
        end

        head_q  <= head_q + PTR_W'(ret_cnt);
        tail_q  <= tail_q + (alloc_en ? PTR_W'(alloc_cnt) : PTR_W'(0));
        count_q <= count_q + (alloc_en ? (PTR_W+1)'(alloc_cnt) : (PTR_W+1)'(0))
                           - (PTR_W+1)'(ret_cnt);
      end
    end
  end

  assign ret_val_out        = ret_val_q;
  assign ret_str_en_out     = ret_str_q;
  assign ret_brch_mode_out  = ret_mode_q;
  assign ret_brch_taken_out = ret_taken_q;
  assign flush_out          = flush_q;
  assign flush_pc_out       = flush_pc_q;

endmodule

// File: tb/tb_rob_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rob_ctrl -- self-checking bench for rob_ctrl.
// A queue of in-flight instructions in program order serves as the reference.
// Directed scenarios pin key behaviours with literal values. A randomized
// phase then compares every output on every cycle.
// -----------------------------------------------------------------------------
module tb_rob_ctrl;
  localparam int DEPTH = 16;
  localparam int PTR_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [3:0]       inst_val_in, str_en_in, spec_brch_in, brch_pred_res_in, no_exe_in, jr_in;
  logic [63:0]      rcvr_pc_in;
  logic [7:0]       brch_mode_in;
  logic             stall_out;
  logic [PTR_W-1:0] alloc_idx_out;
  logic             cmpl0_val, cmpl1_val, cmpl0_taken, cmpl1_taken;
  logic [PTR_W-1:0] cmpl0_idx, cmpl1_idx;
  logic [3:0]       ret_val_out, ret_str_en_out, ret_brch_taken_out;
  logic [7:0]       ret_brch_mode_out;
  logic             flush_out;
  logic [15:0]      flush_pc_out;

  rob_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst),
    .inst_val_in(inst_val_in), .rcvr_pc_in(rcvr_pc_in), .str_en_in(str_en_in),
    .spec_brch_in(spec_brch_in), .brch_mode_in(brch_mode_in),
    .brch_pred_res_in(brch_pred_res_in), .no_exe_in(no_exe_in), .jr_in(jr_in),
    .stall_out(stall_out), .alloc_idx_out(alloc_idx_out),
    .cmpl0_val(cmpl0_val), .cmpl1_val(cmpl1_val),
    .cmpl0_idx(cmpl0_idx), .cmpl1_idx(cmpl1_idx),
    .cmpl0_taken(cmpl0_taken), .cmpl1_taken(cmpl1_taken),
    .ret_val_out(ret_val_out), .ret_str_en_out(ret_str_en_out),
    .ret_brch_mode_out(ret_brch_mode_out), .ret_brch_taken_out(ret_brch_taken_out),
    .flush_out(flush_out), .flush_pc_out(flush_pc_out)
  );

  // Reference: in-flight instructions, oldest first
  typedef struct {
    int        idx;
    bit        done, mis, taken, str, brch, pred, jr;
    bit [1:0]  mode;
    bit [15:0] pc;
  } ent_t;

  ent_t      rob[$];
  int        m_tail;
  bit [3:0]  e_ret_val, e_ret_str, e_ret_taken;
  bit [7:0]  e_ret_mode;
  bit        e_flush;
  bit [15:0] e_flush_pc;

  int n_cmp = 0;
  int n_bad = 0;
  int cmpl_rate;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_complete(input int idx, input bit t);
    foreach (rob[k]) begin
      if (rob[k].idx == idx && !rob[k].done) begin
        rob[k].done  = 1'b1;
        rob[k].taken = t;
        rob[k].mis   = rob[k].brch && (t != rob[k].pred);
      end
    end
  endtask

  // Advance the reference by one clock edge using the inputs now driven.
  task automatic model_step();
    bit stall_now, flush_now, fl;
    int n;
    ent_t e;
    if (rst) begin
      rob.delete();
      m_tail = 0;
      e_ret_val = '0; e_ret_str = '0; e_ret_taken = '0; e_ret_mode = '0;
      e_flush = 1'b0; e_flush_pc = '0;
    end else begin
      stall_now = (DEPTH - rob.size()) < 4;
      flush_now = e_flush;
      e_ret_val = '0; e_ret_str = '0; e_ret_taken = '0; e_ret_mode = '0;
      e_flush_pc = '0;
      fl = 1'b0;
      n = 0;
      for (int k = 0; k < 4; k++) begin
        if (k >= rob.size()) break;
        if (!rob[k].done) break;
        e_ret_val[k] = 1'b1;
        e_ret_str[k] = rob[k].str;
        if (rob[k].brch) begin
          e_ret_taken[k]     = rob[k].taken;
          e_ret_mode[2*k+:2] = rob[k].mode;
        end
        n++;
        if ((rob[k].brch && rob[k].mis) || rob[k].jr) begin
          fl = 1'b1;
          e_flush_pc = rob[k].pc;
          break;
        end
      end
      e_flush = fl;
      if (fl) begin
        rob.delete();
        m_tail = 0;
      end else begin
        repeat (n) void'(rob.pop_front());
        if (cmpl0_val) m_complete(int'(cmpl0_idx), cmpl0_taken);
        if (cmpl1_val && !(cmpl0_val && cmpl0_idx == cmpl1_idx))
          m_complete(int'(cmpl1_idx), cmpl1_taken);
        if (!stall_now && !flush_now) begin
          for (int s = 0; s < 4; s++) begin
            if (inst_val_in[s]) begin
              e.idx = m_tail; e.done = no_exe_in[s]; e.mis = 1'b0; e.taken = 1'b0;
              e.str = str_en_in[s]; e.brch = spec_brch_in[s]; e.pred = brch_pred_res_in[s];
              e.jr = jr_in[s]; e.mode = brch_mode_in[2*s+:2]; e.pc = rcvr_pc_in[16*s+:16];
              rob.push_back(e);
              m_tail = (m_tail + 1) % DEPTH;
            end
          end
        end
      end
    end
  endtask

  task automatic check_all();
    bit e_stall;
    e_stall = (DEPTH - rob.size()) < 4;
    chk("stall_out", stall_out, e_stall);
    chk("alloc_idx_out", alloc_idx_out, m_tail);
    chk("ret_val_out", ret_val_out, e_ret_val);
    chk("ret_str_en_out", ret_str_en_out, e_ret_str);
    chk("ret_brch_mode_out", ret_brch_mode_out, e_ret_mode);
    chk("ret_brch_taken_out", ret_brch_taken_out, e_ret_taken);
    chk("flush_out", flush_out, e_flush);
    chk("flush_pc_out", flush_pc_out, e_flush_pc);
    if (ret_val_out != 4'b0 || flush_out)
      $display("retire t=%0t val=%b str=%b mode=%b taken=%b flush=%b pc=%h",
               $time, ret_val_out, ret_str_en_out, ret_brch_mode_out,
               ret_brch_taken_out, flush_out, flush_pc_out);
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic clr_inputs();
    inst_val_in = '0; rcvr_pc_in = '0; str_en_in = '0; spec_brch_in = '0;
    brch_mode_in = '0; brch_pred_res_in = '0; no_exe_in = '0; jr_in = '0;
    cmpl0_val = 1'b0; cmpl1_val = 1'b0; cmpl0_idx = '0; cmpl1_idx = '0;
    cmpl0_taken = 1'b0; cmpl1_taken = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic gen_random();
    int pop;
    bit alloc_will;
    rst = ($urandom_range(0, 399) == 0);
    inst_val_in = 4'($urandom);
    if ($urandom_range(0, 3) == 0) inst_val_in = '0;
    rcvr_pc_in = {$urandom, $urandom};
    str_en_in  = 4'($urandom);
    brch_mode_in = 8'($urandom);
    brch_pred_res_in = 4'($urandom);
    for (int s = 0; s < 4; s++) begin
      no_exe_in[s]    = ($urandom_range(0, 3) == 0);
      spec_brch_in[s] = ($urandom_range(0, 7) == 0);
      jr_in[s]        = ($urandom_range(0, 15) == 0);
    end
    cmpl0_val = ($urandom_range(0, 99) < cmpl_rate);
    cmpl1_val = ($urandom_range(0, 99) < cmpl_rate);
    cmpl0_taken = 1'($urandom);
    cmpl1_taken = 1'($urandom);
    if (rob.size() > 0 && $urandom_range(0, 9) < 8)
      cmpl0_idx = PTR_W'(rob[$urandom_range(0, rob.size() - 1)].idx);
    else
      cmpl0_idx = PTR_W'($urandom);
    if ($urandom_range(0, 9) == 0)
      cmpl1_idx = cmpl0_idx;
    else if (rob.size() > 0 && $urandom_range(0, 9) < 8)
      cmpl1_idx = PTR_W'(rob[$urandom_range(0, rob.size() - 1)].idx);
    else
      cmpl1_idx = PTR_W'($urandom);
    // Completing an entry in its own allocation cycle is not a legal input.
    pop = $countones(inst_val_in);
    alloc_will = ((DEPTH - rob.size()) >= 4) && !e_flush && (pop != 0);
    if (alloc_will && (((int'(cmpl0_idx) - m_tail) & (DEPTH - 1)) < pop)) cmpl0_val = 1'b0;
    if (alloc_will && (((int'(cmpl1_idx) - m_tail) & (DEPTH - 1)) < pop)) cmpl1_val = 1'b0;
  endtask

  initial begin
    cmpl_rate = 50;

    // Reset state
    do_reset();
    chk("reset stall", stall_out, 0);
    chk("reset alloc_idx", alloc_idx_out, 0);
    chk("reset ret_val", ret_val_out, 0);
    chk("reset flush", flush_out, 0);

    // Four no-exe slots retire together two cycles after allocation
    inst_val_in = 4'b1111; no_exe_in = 4'b1111;
    chk("first alloc_idx", alloc_idx_out, 0);
    tick();
    clr_inputs();
    chk("alloc_idx after 4", alloc_idx_out, 4);
    tick();
    chk("ret 1111", ret_val_out, 4'b1111);
    tick();
    chk("ret cleared", ret_val_out, 4'b0000);
    chk("empty stall", stall_out, 0);

    // Sparse slots compact into entries 0 and 1
    do_reset();
    inst_val_in = 4'b1010; no_exe_in = 4'b1010; jr_in = 4'b1000; str_en_in = 4'b0010;
    rcvr_pc_in = 64'h3333_2222_1111_0000;
    tick();
    clr_inputs();
    chk("sparse alloc_idx", alloc_idx_out, 2);
    tick();
    chk("sparse ret_val", ret_val_out, 4'b0011);
    chk("sparse ret_str", ret_str_en_out, 4'b0001);
    chk("sparse flush", flush_out, 1);
    chk("sparse flush_pc", flush_pc_out, 16'h3333);
    tick();
    chk("sparse post-flush", flush_out, 0);
    chk("sparse post-flush idx", alloc_idx_out, 0);

    // Fill to 13 entries: stalled, alloc ignored until a retire frees space
    do_reset();
    inst_val_in = 4'b1111;
    tick(); tick(); tick();
    chk("count12 stall", stall_out, 0);
    chk("count12 idx", alloc_idx_out, 12);
    inst_val_in = 4'b0001;
    tick();
    chk("count13 stall", stall_out, 1);
    chk("count13 idx", alloc_idx_out, 13);
    inst_val_in = 4'b1111;
    tick(); tick();
    chk("stalled idx held", alloc_idx_out, 13);
    clr_inputs();
    cmpl0_val = 1'b1; cmpl0_idx = 4'd0;
    tick();
    clr_inputs();
    tick();
    chk("unstall ret", ret_val_out, 4'b0001);
    chk("unstall stall", stall_out, 0);

    // Mispredicted branch at entry 2 ends the group and flushes
    do_reset();
    inst_val_in = 4'b1111; no_exe_in = 4'b1010; spec_brch_in = 4'b0100;
    brch_pred_res_in = 4'b0100; brch_mode_in = 8'b0010_0000;
    rcvr_pc_in = 64'hDDDD_BEEF_BBBB_AAAA;
    tick();
    clr_inputs();
    cmpl1_val = 1'b1; cmpl1_idx = 4'd2; cmpl1_taken = 1'b0;
    tick();
    clr_inputs();
    cmpl0_val = 1'b1; cmpl0_idx = 4'd0;
    tick();
    clr_inputs();
    tick();
    chk("mispred ret_val", ret_val_out, 4'b0111);
    chk("mispred flush", flush_out, 1);
    chk("mispred flush_pc", flush_pc_out, 16'hBEEF);
    chk("mispred mode", ret_brch_mode_out, 8'h20);
    chk("mispred taken", ret_brch_taken_out, 4'b0000);
    tick();
    chk("mispred flush 1cyc", flush_out, 0);
    chk("mispred idx reset", alloc_idx_out, 0);

    // jr at entry 0 retires alone; the done entry behind it is discarded
    do_reset();
    inst_val_in = 4'b0011; jr_in = 4'b0001; no_exe_in = 4'b0010;
    rcvr_pc_in = 64'h0000_0000_5678_1234;
    tick();
    clr_inputs();
    cmpl0_val = 1'b1; cmpl0_idx = 4'd0;
    tick();
    clr_inputs();
    tick();
    chk("jr ret_val", ret_val_out, 4'b0001);
    chk("jr flush", flush_out, 1);
    chk("jr flush_pc", flush_pc_out, 16'h1234);

    // Both ports on entry 5: port 0 (taken, correct) wins, no flush
    do_reset();
    inst_val_in = 4'b1111; no_exe_in = 4'b1111;
    tick();
    inst_val_in = 4'b1111; no_exe_in = 4'b1101; spec_brch_in = 4'b0010;
    brch_pred_res_in = 4'b0010; brch_mode_in = 8'b0000_1100;
    tick();
    clr_inputs();
    tick();
    chk("dual pre ret", ret_val_out, 4'b0001);
    cmpl0_val = 1'b1; cmpl0_idx = 4'd5; cmpl0_taken = 1'b1;
    cmpl1_val = 1'b1; cmpl1_idx = 4'd5; cmpl1_taken = 1'b0;
    tick();
    clr_inputs();
    tick();
    chk("dual ret_val", ret_val_out, 4'b0111);
    chk("dual flush", flush_out, 0);
    chk("dual mode", ret_brch_mode_out, 8'h03);
    chk("dual taken", ret_brch_taken_out, 4'b0001);

    // Randomized phase, completion rate varied to exercise stall and drain
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) cmpl_rate = $urandom_range(0, 100);
      gen_random();
      tick();
    end
    rst = 1'b0;
    clr_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
